// File: rtl/regfile_wb_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | regfile_wb_arbiter_if : write-back request, register-file write port and |
// | decode hazard signals of regfile_wb_arbiter.                  Rev 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

interface regfile_wb_arbiter_if #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 32
);
   logic [NREQ-1:0]    iReqValid;
   logic [NREQ-1:0]    oReqReady;
   logic [NREQ*AW-1:0] iReqAddr;
   logic [NREQ*DW-1:0] iReqData;
   logic               oWrite;
   logic [AW-1:0]      oAddrC;
   logic [DW-1:0]      oRegC;
   logic               iIssue;
   logic [AW-1:0]      iIssueAddr;
   logic [AW-1:0]      iAddrA;
   logic [AW-1:0]      iAddrB;
   logic               oBusyA;
   logic               oBusyB;
   logic               oErr;
   logic               oFwdHitA;
   logic               oFwdHitB;

   modport master (
      output iReqValid, iReqAddr, iReqData, iIssue, iIssueAddr, iAddrA, iAddrB,
      input  oReqReady, oWrite, oAddrC, oRegC, oBusyA, oBusyB, oErr,
             oFwdHitA, oFwdHitB
   );

   modport slave (
      input  iReqValid, iReqAddr, iReqData, iIssue, iIssueAddr, iAddrA, iAddrB,
      output oReqReady, oWrite, oAddrC, oRegC, oBusyA, oBusyB, oErr,
             oFwdHitA, oFwdHitB
   );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// +--------------------------------------------------------------------------+
// | regfile_wb_arbiter : round-robin write-back arbiter for a single-port    |
// | register file with a pending-write hazard scoreboard.                    |
// | Optional macro WB_BYPASS_EN adds forward-hit outputs and busy masking.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  wire logic          iClk,
   input  wire logic          iRst,
   regfile_wb_arbiter_if.slave bus
);

   localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int c_NREG  = 1 << AW;

   logic [c_PTR_W-1:0] r_ptr;
   logic               r_write;
   logic [AW-1:0]      r_addr;
   logic [DW-1:0]      r_data;
   logic [c_NREG-1:0]  r_pend;
   logic               r_err;

   int                 w_scan;
   logic               w_gnt;
   logic [c_PTR_W-1:0] w_gnt_idx;
   logic [AW-1:0]      w_gnt_addr;
   logic [DW-1:0]      w_gnt_data;
   logic [NREQ-1:0]    w_ready;
   logic [c_PTR_W-1:0] w_ptr_next;
   logic [c_NREG-1:0]  w_set;
   logic [c_NREG-1:0]  w_clr;
   logic               w_err_issue;
   logic               w_err_gnt;
   logic               w_hit_a;
   logic               w_hit_b;

   // Scan from the pointer, wrapping by subtraction rather than modulo.
   always_comb begin
      w_scan    = 0;
      w_gnt     = 1'b0;
      w_gnt_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_scan = int'(r_ptr) + i;
         if (w_scan >= NREQ) begin
            w_scan = w_scan - NREQ;
         end
         if (!w_gnt && bus.iReqValid[w_scan]) begin
            w_gnt     = 1'b1;
            w_gnt_idx = c_PTR_W'(w_scan);
         end
      end
      if (iRst) begin
         w_gnt = 1'b0;
      end
      w_ready    = w_gnt ? (NREQ'(1) << w_gnt_idx) : '0;
      w_gnt_addr = bus.iReqAddr[w_gnt_idx*AW +: AW];
      w_gnt_data = bus.iReqData[w_gnt_idx*DW +: DW];
      w_ptr_next = (w_gnt_idx == c_PTR_W'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
   end

   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (bus.iIssue && (bus.iIssueAddr != '0)) begin
         w_set[bus.iIssueAddr] = 1'b1;
      end
      if (w_gnt && (w_gnt_addr != '0)) begin
         w_clr[w_gnt_addr] = 1'b1;
      end
      // Re-issuing a register whose old writer retires this cycle is legal.
      w_err_issue = bus.iIssue && (bus.iIssueAddr != '0) &&
                    r_pend[bus.iIssueAddr] && !w_clr[bus.iIssueAddr];
      w_err_gnt   = w_gnt && (w_gnt_addr != '0) && !r_pend[w_gnt_addr];
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_ptr   <= '0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_pend  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_write <= w_gnt && (w_gnt_addr != '0);
         if (w_gnt) begin
            r_ptr  <= w_ptr_next;
            r_addr <= w_gnt_addr;
            r_data <= w_gnt_data;
         end
         // Set after clear so a new issue wins over the retiring writer.
         r_pend <= ((r_pend & ~w_clr) | w_set) & {{(c_NREG-1){1'b1}}, 1'b0};
         if (w_err_issue || w_err_gnt) begin
            r_err <= 1'b1;
         end
      end
   end

`ifdef WB_BYPASS_EN
   assign w_hit_a = r_write && (r_addr == bus.iAddrA) && (bus.iAddrA != '0);
   assign w_hit_b = r_write && (r_addr == bus.iAddrB) && (bus.iAddrB != '0);
`else
   assign w_hit_a = 1'b0;
   assign w_hit_b = 1'b0;
`endif

   assign bus.oReqReady = w_ready;
   assign bus.oWrite    = r_write;
   assign bus.oAddrC    = r_addr;
   assign bus.oRegC     = r_data;
   assign bus.oBusyA    = r_pend[bus.iAddrA] & ~w_hit_a;
   assign bus.oBusyB    = r_pend[bus.iAddrB] & ~w_hit_b;
   assign bus.oErr      = r_err;
   assign bus.oFwdHitA  = w_hit_a;
   assign bus.oFwdHitB  = w_hit_b;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_regfile_wb_arbiter : directed self-checking bench for the write-back  |
// | arbiter, expected writes queued at grant and popped one cycle later.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_wb_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam bit c_BYP =
`ifdef WB_BYPASS_EN
      1'b1;
`else
      1'b0;
`endif

   typedef struct packed {
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wb_t;

   logic iClk = 1'b0;
   logic iRst;
   int   checks = 0;
   int   errors = 0;
   wb_t  exp_q[$];
   logic [AW-1:0] last_a;
   logic [DW-1:0] last_d;

   always #5 iClk = ~iClk;

   regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

   regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .iClk (iClk),
      .iRst (iRst),
      .bus  (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.iReqAddr[k*AW +: AW] = a;
      bus.iReqData[k*DW +: DW] = d;
   endtask

   // One clock: check the grant, queue the expected write, then check it.
   task automatic step(input string tag, input logic [NREQ-1:0] exp_ready);
      wb_t e;
      #1;
      chk({tag, "_ready"}, 64'(bus.oReqReady), 64'(exp_ready));
      e.w = 1'b0;
      e.a = last_a;
      e.d = last_d;
      for (int k = 0; k < NREQ; k++) begin
         if (exp_ready[k]) begin
            e.a = bus.iReqAddr[k*AW +: AW];
            e.d = bus.iReqData[k*DW +: DW];
            e.w = (e.a != '0);
         end
      end
      last_a = e.a;
      last_d = e.d;
      exp_q.push_back(e);
      @(posedge iClk);
      #1;
      e = exp_q.pop_front();
      chk({tag, "_write"}, 64'(bus.oWrite), 64'(e.w));
      chk({tag, "_addr"},  64'(bus.oAddrC), 64'(e.a));
      chk({tag, "_data"},  64'(bus.oRegC),  64'(e.d));
   endtask

   task automatic issue(input logic [AW-1:0] a);
      bus.iIssue     = 1'b1;
      bus.iIssueAddr = a;
      step("issue", '0);
      bus.iIssue     = 1'b0;
   endtask

   initial begin
      // Reset with garbage on every input.
      iRst           = 1'b1;
      bus.iReqValid  = '1;
      bus.iReqAddr   = 15'h5A5A;
      bus.iReqData   = {32'hFFFF0000, 32'h12345678, 32'h9ABCDEF0};
      bus.iIssue     = 1'b1;
      bus.iIssueAddr = 5'd9;
      bus.iAddrA     = 5'd9;
      bus.iAddrB     = 5'd10;
      repeat (2) @(posedge iClk);
      #1;
      chk("rst_ready", 64'(bus.oReqReady), 64'd0);
      chk("rst_write", 64'(bus.oWrite), 64'd0);
      chk("rst_addr",  64'(bus.oAddrC), 64'd0);
      chk("rst_data",  64'(bus.oRegC), 64'd0);
      chk("rst_busya", 64'(bus.oBusyA), 64'd0);
      chk("rst_busyb", 64'(bus.oBusyB), 64'd0);
      chk("rst_err",   64'(bus.oErr), 64'd0);
      iRst           = 1'b0;
      bus.iReqValid  = '0;
      bus.iReqAddr   = '0;
      bus.iReqData   = '0;
      bus.iIssue     = 1'b0;
      bus.iIssueAddr = '0;
      bus.iAddrA     = '0;
      bus.iAddrB     = '0;
      last_a         = '0;
      last_d         = '0;

      // Fairness: grants 0,1,2,0,1,2; first round re-issues each register.
      issue(5'd1);
      issue(5'd2);
      issue(5'd3);
      set_req(0, 5'd1, 32'hA000_0001);
      set_req(1, 5'd2, 32'hA000_0002);
      set_req(2, 5'd3, 32'hA000_0003);
      bus.iReqValid = 3'b111;
      bus.iIssue = 1'b1;
      bus.iIssueAddr = 5'd1; step("rr0", 3'b001);
      bus.iIssueAddr = 5'd2; step("rr1", 3'b010);
      bus.iIssueAddr = 5'd3; step("rr2", 3'b100);
      bus.iIssue = 1'b0;
      step("rr3", 3'b001);
      step("rr4", 3'b010);
      step("rr5", 3'b100);
      bus.iReqValid = '0;
      bus.iAddrA = 5'd1;
      chk("rr_busy1", 64'(bus.oBusyA), 64'd0);
      chk("rr_err", 64'(bus.oErr), 64'd0);

      // Single request from requester 1.
      issue(5'd5);
      set_req(1, 5'd5, 32'hDEAD_BEEF);
      bus.iReqValid = 3'b010;
      step("single", 3'b010);
      bus.iReqValid = '0;
      step("single_idle", 3'b000);

      // Scoreboard busy until the write-back retires.
      bus.iAddrA = 5'd7;
      issue(5'd7);
      chk("sb_busy_set", 64'(bus.oBusyA), 64'd1);
      set_req(0, 5'd7, 32'h7777_7777);
      bus.iReqValid = 3'b001;
      chk("sb_busy_pre", 64'(bus.oBusyA), 64'd1);
      step("sb_grant", 3'b001);
      bus.iReqValid = '0;
      chk("sb_busy_clr", 64'(bus.oBusyA), 64'd0);

      // Same-cycle issue and retire of register 7: the bit stays set.
      issue(5'd7);
      bus.iIssue = 1'b1;
      bus.iIssueAddr = 5'd7;
      bus.iReqValid = 3'b001;
      step("sb_same", 3'b001);
      bus.iIssue = 1'b0;
      bus.iReqValid = '0;
      chk("sb_same_busy", 64'(bus.oBusyA), c_BYP ? 64'd0 : 64'd1);
      chk("sb_same_err", 64'(bus.oErr), 64'd0);
      step("sb_idle", 3'b000);
      chk("sb_hold_busy", 64'(bus.oBusyA), 64'd1);

      // Register 0: consumed without a write strobe, never busy.
      set_req(2, 5'd0, 32'h0000_1234);
      bus.iReqValid = 3'b100;
      step("r0_grant", 3'b100);
      bus.iReqValid = '0;
      bus.iAddrA = 5'd0;
      issue(5'd0);
      chk("r0_busy", 64'(bus.oBusyA), 64'd0);
      chk("r0_err", 64'(bus.oErr), 64'd0);

      // Write to 4 retiring while 4 is re-issued, observed on read port B.
      issue(5'd4);
      bus.iAddrB = 5'd4;
      set_req(1, 5'd4, 32'hCAFE_F00D);
      bus.iReqValid = 3'b010;
      bus.iIssue = 1'b1;
      bus.iIssueAddr = 5'd4;
      step("byp_grant", 3'b010);
      bus.iReqValid = '0;
      bus.iIssue = 1'b0;
      chk("byp_fwdb", 64'(bus.oFwdHitB), 64'(c_BYP));
      chk("byp_fwda", 64'(bus.oFwdHitA), 64'd0);
      chk("byp_busyb", 64'(bus.oBusyB), c_BYP ? 64'd0 : 64'd1);
      chk("byp_err", 64'(bus.oErr), 64'd0);

      // Double issue without write-back raises a sticky error.
      issue(5'd9);
      chk("err_first", 64'(bus.oErr), 64'd0);
      issue(5'd9);
      chk("err_set", 64'(bus.oErr), 64'd1);
      step("err_idle0", 3'b000);
      step("err_idle1", 3'b000);
      chk("err_sticky", 64'(bus.oErr), 64'd1);
      iRst = 1'b1;
      @(posedge iClk);
      #1;
      iRst = 1'b0;
      chk("err_rst", 64'(bus.oErr), 64'd0);
      chk("rst2_busyb", 64'(bus.oBusyB), 64'd0);
      chk("rst2_addr", 64'(bus.oAddrC), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back scheduler for the CPU register file, which has a single write port (write strobe, 5-bit write address, 32-bit write data).
- Arbitrates NREQ write-back requesters (ALU, load unit, multiplier) onto that port with round-robin fairness.
- Keeps a pending-write scoreboard so decode can detect read-after-write hazards on read addresses A/B.
- Sits between the execute/memory units and the register file; its outputs drive the register file write port directly.

Parameters:
- NREQ, 3, number of write-back requesters (2..8).
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- iClk  input  1  clock; all state updates on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iReqValid  input  NREQ  per-requester write-back request.
- oReqReady  output  NREQ  per-requester grant; combinational, one-hot or zero.
- iReqAddr  input  NREQ*AW  per-requester destination register, requester k at bits [k*AW +: AW].
- iReqData  input  NREQ*DW  per-requester result, requester k at bits [k*DW +: DW].
- oWrite  output  1  register file write strobe.
- oAddrC  output  AW  register file write address.
- oRegC  output  DW  register file write data.
- iIssue  input  1  decode issued an instruction that will write iIssueAddr.
- iIssueAddr  input  AW  destination register of the issued instruction.
- iAddrA  input  AW  decode read address A.
- iAddrB  input  AW  decode read address B.
- oBusyA  output  1  register iAddrA has a pending write.
- oBusyB  output  1  register iAddrB has a pending write.
- oErr  output  1  sticky protocol error flag.
- oFwdHitA  output  1  forward hit on read address A; used only when the bypass feature is compiled in.
- oFwdHitB  output  1  forward hit on read address B; used only when the bypass feature is compiled in.

Behaviour:
- Reset (iRst high at a clock edge):
  - oWrite=0, oAddrC=0, oRegC=0, oErr=0.
  - Scoreboard cleared to 0.
  - Round-robin pointer = 0.
  - Reset has priority over all other activity; an in-flight output write is dropped.
- Arbitration (combinational):
  - Search requesters starting at the pointer and wrapping modulo NREQ.
  - The first k with iReqValid[k]=1 gets oReqReady[k]=1; all other ready bits are 0.
  - oReqReady is 0 everywhere while iRst=1.
  - A request completes when valid and ready are both 1 at a clock edge.
  - A requester holds valid, addr and data stable until granted.
- Pointer update: on a grant to k, the pointer becomes (k+1) mod NREQ. With no grant, the pointer holds.
- Output stage (registered, latency 1 cycle from grant edge to oWrite):
  - The granted addr/data are captured into oAddrC/oRegC.
  - oWrite=1 for exactly one cycle, unless the address is 0.
  - Address 0 grant: the request is accepted (consumed) but oWrite=0; oAddrC/oRegC still update.
  - With no grant, oWrite=0 and oAddrC/oRegC hold their previous values.
- Scoreboard: one pending bit per register; bit 0 is always 0.
  - Set: iIssue=1 and iIssueAddr!=0 sets bit[iIssueAddr] at the edge.
  - Clear: a completed grant with addr a!=0 clears bit[a] at the same edge as the capture.
  - Same register set and cleared in one cycle: set wins; the bit ends at 1, representing the new writer.
  - oBusyA = bit[iAddrA]; oBusyB = bit[iAddrB]; both combinational.
- Error flag: oErr is set and held until reset on either of:
  - iIssue to a register whose bit is already 1, unless that bit is being cleared in the same cycle;
  - a grant to a register whose bit is 0, for a nonzero address.
- Throughput: one write-back per cycle. The register file write completes in one cycle, so there is no backpressure from the output stage.
- NREQ=1: the pointer is constant 0; grant = valid.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - oFwdHitA = oWrite && (oAddrC==iAddrA) && (iAddrA!=0); oFwdHitB is the same using iAddrB.
  - Decode muxes oRegC in place of register file data on a hit.
  - oBusyA/oBusyB are masked to 0 on a hit, since that register's write is completing now and its bit was cleared at the previous edge or is re-set by a new issue.
- Not defined: oFwdHitA=oFwdHitB=0; oBusyA/oBusyB are unmasked.

Test Plan:
- Reset: drive garbage on all inputs with iRst=1 for 2 cycles -> oWrite=0, oAddrC=0, oRegC=0, oBusyA=oBusyB=0, oErr=0, oReqReady=0.
- Single request: requester 1 requests addr 5, data 0xDEADBEEF -> oReqReady=3'b010 that cycle; next cycle oWrite=1, oAddrC=5, oRegC=0xDEADBEEF; following cycle oWrite=0.
- Fairness: all 3 requesters hold valid (addrs 1/2/3) for 6 cycles -> grant order 0,1,2,0,1,2; each write appears one cycle after its grant.
- Scoreboard: issue addr 7, then iAddrA=7 -> oBusyA=1 until the cycle after the requester-0 grant to addr 7; same-cycle issue 7 plus grant 7 -> bit stays 1, oErr=0.
- Register 0: grant to addr 0 with data 0x1234 -> oWrite=0 next cycle; issue to addr 0 -> oBusyA=0 for iAddrA=0; oErr=0.
- Errors and bypass: issue 9 twice without a write-back -> oErr=1, sticky until iRst. With WB_BYPASS_EN defined, iAddrB=4 while oWrite=1 and oAddrC=4 -> oFwdHitB=1, oBusyB=0.
